// File: rtl/prescaled_pwm_timer_if.sv
// rtl/prescaled_pwm_timer_if.sv - command-side and output bundle of the PWM timebase
interface prescaled_pwm_timer_if #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 8,
  parameter int N_CH  = 2
) ();
  logic                    en;
  logic [PSC_W-1:0]        psc_in;
  logic [CNT_W-1:0]        top_in;
  logic                    mode_in;
  logic                    cfg_load;
  logic [N_CH*CNT_W-1:0]   cmp_in;
  logic                    cmp_load;
  logic [CNT_W-1:0]        cnt_out;
  logic                    dir_out;
  logic                    tick;
  logic                    period_end;
  logic [N_CH-1:0]         pwm_out;

  modport master (
    output en, psc_in, top_in, mode_in, cfg_load, cmp_in, cmp_load,
    input  cnt_out, dir_out, tick, period_end, pwm_out
  );

  modport slave (
    input  en, psc_in, top_in, mode_in, cfg_load, cmp_in, cmp_load,
    output cnt_out, dir_out, tick, period_end, pwm_out
  );
endinterface

// File: rtl/prescaled_pwm_timer.sv
// rtl/prescaled_pwm_timer.sv - prescaled up or up/down PWM timebase with double-buffered config
module prescaled_pwm_timer #(
  parameter int CNT_W    = 16,
  parameter int PSC_W    = 8,
  parameter int N_CH     = 2,
  parameter int DEF_PSC  = 99,
  parameter int DEF_TOP  = 19999,
  parameter int DEF_MODE = 0
) (
  input logic clk,
  input logic rst,
  prescaled_pwm_timer_if.slave bus
);

  localparam logic [PSC_W-1:0] RST_PSC  = PSC_W'(DEF_PSC);
  localparam logic [CNT_W-1:0] RST_TOP  = CNT_W'(DEF_TOP);
  localparam logic             RST_MODE = (DEF_MODE != 0);

  logic [PSC_W-1:0]      psc_cnt, psc_act, psc_sh;
  logic [CNT_W-1:0]      cnt, top_act, top_sh;
  logic                  mode_act, mode_sh;
  logic                  dir, tick_q, pend_q;
  logic [N_CH-1:0]       pwm_q;
  logic [N_CH*CNT_W-1:0] cmp_act, cmp_sh;

  logic                  itick, boundary, dir_nx;
  logic [CNT_W-1:0]      cnt_nx;
  logic [N_CH*CNT_W-1:0] cmp_nx;
  logic [N_CH-1:0]       pwm_nx;

  assign itick = bus.en && (psc_cnt == psc_act);

  // Triangle mode with top 0 has no up/down phases, so every tick closes a period.
  assign boundary = itick && (mode_act ? ((top_act == '0) || (dir && (cnt == CNT_W'(1))))
                                       : (cnt == top_act));

  always_comb begin
    cnt_nx = cnt;
    dir_nx = dir;
    cmp_nx = cmp_act;
    if (boundary) begin
      cnt_nx = '0;
      dir_nx = 1'b0;
      cmp_nx = cmp_sh;
    end else if (itick) begin
      if (!mode_act) begin
        cnt_nx = cnt + CNT_W'(1);
      end else if (!dir) begin
        cnt_nx = cnt + CNT_W'(1);
        dir_nx = (cnt_nx == top_act);
      end else begin
        cnt_nx = cnt - CNT_W'(1);
      end
    end
  end

  // Compare against next-state values so pwm_out lines up with cnt_out without a cycle of lag.
  always_comb begin
    pwm_nx = '0;
    for (int i = 0; i < N_CH; i++) begin
      pwm_nx[i] = (cnt_nx < cmp_nx[i*CNT_W +: CNT_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_cnt  <= '0;
      cnt      <= '0;
      dir      <= 1'b0;
      tick_q   <= 1'b0;
      pend_q   <= 1'b0;
      pwm_q    <= '0;
      psc_act  <= RST_PSC;
      psc_sh   <= RST_PSC;
      top_act  <= RST_TOP;
      top_sh   <= RST_TOP;
      mode_act <= RST_MODE;
      mode_sh  <= RST_MODE;
      cmp_act  <= '0;
      cmp_sh   <= '0;
    end else begin
      if (bus.en) begin
        psc_cnt <= itick ? '0 : psc_cnt + PSC_W'(1);
      end
      cnt     <= cnt_nx;
      dir     <= dir_nx;
      cmp_act <= cmp_nx;
      pwm_q   <= pwm_nx;
      tick_q  <= itick;
      pend_q  <= boundary;
      if (boundary) begin
        psc_act  <= psc_sh;
        top_act  <= top_sh;
        mode_act <= mode_sh;
      end
      // A load coinciding with a boundary lands in the shadow only; the copy above sees the old shadow.
      if (bus.cfg_load) begin
        psc_sh  <= bus.psc_in;
        top_sh  <= bus.top_in;
        mode_sh <= bus.mode_in;
      end
      if (bus.cmp_load) begin
        cmp_sh <= bus.cmp_in;
      end
    end
  end

  assign bus.cnt_out    = cnt;
  assign bus.dir_out    = dir;
  assign bus.tick       = tick_q;
  assign bus.period_end = pend_q;
  assign bus.pwm_out    = pwm_q;

endmodule

// File: tb/tb_prescaled_pwm_timer.sv
// tb/tb_prescaled_pwm_timer.sv - directed self-checking bench for prescaled_pwm_timer
module tb_prescaled_pwm_timer;
  localparam int CNT_W    = 16;
  localparam int PSC_W    = 8;
  localparam int N_CH     = 2;
  localparam int DEF_PSC  = 99;
  // Short reset period keeps the first boundary reachable in a few hundred clocks.
  localparam int DEF_TOP  = 3;
  localparam int DEF_MODE = 0;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  prescaled_pwm_timer_if #(.CNT_W(CNT_W), .PSC_W(PSC_W), .N_CH(N_CH)) bus ();

  prescaled_pwm_timer #(
    .CNT_W(CNT_W), .PSC_W(PSC_W), .N_CH(N_CH),
    .DEF_PSC(DEF_PSC), .DEF_TOP(DEF_TOP), .DEF_MODE(DEF_MODE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int p, input int t, input int m);
    bus.psc_in   = PSC_W'(p);
    bus.top_in   = CNT_W'(t);
    bus.mode_in  = m[0];
    bus.cfg_load = 1'b1;
  endtask

  task automatic set_cmp(input int c1, input int c0);
    bus.cmp_in   = {CNT_W'(c1), CNT_W'(c0)};
    bus.cmp_load = 1'b1;
  endtask

  task automatic wait_pend(input int limit, input string tag);
    int n = 0;
    while (!bus.period_end && n < limit) begin
      cyc();
      n++;
    end
    chk(tag, 32'(bus.period_end), 32'd1);
  endtask

  initial begin
    int n;
    int last;
    int c;
    logic [1:0] ep;
    int seq3[16] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 2, 2, 1, 1};

    rst = 1'b1;
    bus.en = 1'b0;
    bus.psc_in = '0;
    bus.top_in = '0;
    bus.mode_in = 1'b0;
    bus.cfg_load = 1'b0;
    bus.cmp_in = '0;
    bus.cmp_load = 1'b0;
    cyc();
    cyc();
    chk("rst_cnt", 32'(bus.cnt_out), 0);
    chk("rst_dir", 32'(bus.dir_out), 0);
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_pend", 32'(bus.period_end), 0);
    chk("rst_pwm", 32'(bus.pwm_out), 0);

    // Test 1: sawtooth psc=3 top=9, applied at the first (default) boundary
    rst = 1'b0;
    bus.en = 1'b1;
    set_cfg(3, 9, 0);
    cyc();
    bus.cfg_load = 1'b0;
    n = 1;
    while (!bus.period_end && n < 1000) begin
      cyc();
      n++;
    end
    chk("t1_first_boundary_clks", n, 400);
    for (int k = 1; k <= 80; k++) begin
      cyc();
      chk("t1_tick", 32'(bus.tick), 32'(k % 4 == 0));
      chk("t1_cnt", 32'(bus.cnt_out), (k / 4) % 10);
      chk("t1_pend", 32'(bus.period_end), 32'(k % 40 == 0));
      chk("t1_dir", 32'(bus.dir_out), 0);
      chk("t1_pwm", 32'(bus.pwm_out), 0);
    end

    // Test 2: psc=0 top=9, cmp ch0=3 ch1=0, then ch1=12
    set_cfg(0, 9, 0);
    set_cmp(0, 3);
    cyc();
    bus.cfg_load = 1'b0;
    bus.cmp_load = 1'b0;
    wait_pend(100, "t2_boundary");
    chk("t2_cnt0", 32'(bus.cnt_out), 0);
    chk("t2_pwm0", 32'(bus.pwm_out), 1);
    for (int k = 1; k <= 50; k++) begin
      if (k == 21) set_cmp(12, 3);
      cyc();
      bus.cmp_load = 1'b0;
      c = k % 10;
      ep = {1'(k >= 30), 1'(c < 3)};
      chk("t2_cnt", 32'(bus.cnt_out), c);
      chk("t2_tick", 32'(bus.tick), 1);
      chk("t2_pend", 32'(bus.period_end), 32'(c == 0));
      chk("t2_pwm", 32'(bus.pwm_out), 32'(ep));
    end

    // Test 3: triangle psc=1 top=4, cmp ch0=2 ch1=5
    set_cfg(1, 4, 1);
    set_cmp(5, 2);
    cyc();
    bus.cfg_load = 1'b0;
    bus.cmp_load = 1'b0;
    wait_pend(50, "t3_boundary");
    chk("t3_cnt0", 32'(bus.cnt_out), 0);
    chk("t3_dir0", 32'(bus.dir_out), 0);
    chk("t3_pwm0", 32'(bus.pwm_out), 3);
    for (int k = 1; k <= 32; k++) begin
      cyc();
      c = seq3[k % 16];
      ep = {1'b1, 1'(c < 2)};
      chk("t3_cnt", 32'(bus.cnt_out), c);
      chk("t3_dir", 32'(bus.dir_out), 32'(k % 16 >= 8));
      chk("t3_tick", 32'(bus.tick), 32'(k % 2 == 0));
      chk("t3_pend", 32'(bus.period_end), 32'(k % 16 == 0));
      chk("t3_pwm", 32'(bus.pwm_out), 32'(ep));
    end

    // Test 4: top changes mid-period and on the boundary tick itself
    set_cfg(0, 9, 0);
    set_cmp(9, 2);
    cyc();
    bus.cfg_load = 1'b0;
    bus.cmp_load = 1'b0;
    wait_pend(50, "t4_boundary");
    last = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5)  set_cfg(0, 5, 0);
      if (k == 22) set_cfg(0, 7, 0);
      cyc();
      bus.cfg_load = 1'b0;
      if (k == 10 || k == 16 || k == 22 || k == 28 || k == 36) last = k;
      c = k - last;
      ep = {1'(c < 9), 1'(c < 2)};
      chk("t4_cnt", 32'(bus.cnt_out), c);
      chk("t4_pend", 32'(bus.period_end), 32'(k == last));
      chk("t4_pwm", 32'(bus.pwm_out), 32'(ep));
    end

    // Test 5: en low for 7 cycles at cnt_out=6 with a compare load parked meanwhile
    cyc();
    cyc();
    chk("t5_cnt_before", 32'(bus.cnt_out), 6);
    bus.en = 1'b0;
    set_cmp(4, 3);
    for (int j = 1; j <= 7; j++) begin
      cyc();
      bus.cmp_load = 1'b0;
      chk("t5_hold_cnt", 32'(bus.cnt_out), 6);
      chk("t5_hold_tick", 32'(bus.tick), 0);
      chk("t5_hold_pend", 32'(bus.period_end), 0);
      chk("t5_hold_pwm", 32'(bus.pwm_out), 2);
    end
    bus.en = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      cyc();
      c = (j == 1) ? 7 : j - 2;
      ep = (j == 1) ? 2'b10 : {1'(c < 4), 1'(c < 3)};
      chk("t5_cnt", 32'(bus.cnt_out), c);
      chk("t5_tick", 32'(bus.tick), 1);
      chk("t5_pend", 32'(bus.period_end), 32'(j == 2));
      chk("t5_pwm", 32'(bus.pwm_out), 32'(ep));
    end

    // Test 6: reset at cnt_out=8, then defaults govern the prescaler and period
    set_cfg(0, 9, 0);
    set_cmp(9, 5);
    cyc();
    bus.cfg_load = 1'b0;
    bus.cmp_load = 1'b0;
    wait_pend(20, "t6_boundary");
    for (int k = 1; k <= 8; k++) cyc();
    chk("t6_cnt_pre", 32'(bus.cnt_out), 8);
    chk("t6_pwm_pre", 32'(bus.pwm_out), 2);
    rst = 1'b1;
    cyc();
    chk("t6_rst_cnt", 32'(bus.cnt_out), 0);
    chk("t6_rst_pwm", 32'(bus.pwm_out), 0);
    chk("t6_rst_tick", 32'(bus.tick), 0);
    chk("t6_rst_pend", 32'(bus.period_end), 0);
    chk("t6_rst_dir", 32'(bus.dir_out), 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      n++;
      chk("t6_no_early_tick", 32'(bus.tick), 0);
    end
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t6_gap_tick", 32'(bus.tick), 0);
      chk("t6_gap_cnt", 32'(bus.cnt_out), 0);
    end
    bus.en = 1'b1;
    while (!bus.tick && n < 300) begin
      cyc();
      n++;
    end
    chk("t6_first_tick_clks", n, 100);
    chk("t6_first_tick_cnt", 32'(bus.cnt_out), 1);
    while (!bus.period_end && n < 1000) begin
      cyc();
      n++;
    end
    chk("t6_default_period_clks", n, 400);
    chk("t6_pwm_after", 32'(bus.pwm_out), 0);

    // Triangle mode with top=0: counter parked at 0, every tick a boundary
    set_cfg(0, 0, 1);
    cyc();
    bus.cfg_load = 1'b0;
    wait_pend(500, "t7_boundary");
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("t7_cnt", 32'(bus.cnt_out), 0);
      chk("t7_pend", 32'(bus.period_end), 1);
      chk("t7_tick", 32'(bus.tick), 1);
      chk("t7_dir", 32'(bus.dir_out), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
